// File: rtl/dct_sched_pkg.sv
// Shared definitions for the 2-D DCT pass scheduler: block edge, counter
// width and the scheduler state encoding.
package dct_sched_pkg;

  localparam int DCT_N = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    S_ROW      = 2'd0,
    S_ROW_WAIT = 2'd1,
    S_COL      = 2'd2,
    S_COL_WAIT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic en);
    return c + {{(CNT_W-1){1'b0}}, en};
  endfunction

endpackage

// File: rtl/dct_tpose_buf.sv
// 8x8 transpose buffer: whole-row writes, combinational whole-column reads.
// Contents are deliberately not reset.
module dct_tpose_buf
  import dct_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = DCT_N
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_row,
  input  logic [DATA_W-1:0] i_wr_data [N],
  input  logic [IDX_W-1:0]  i_rd_col,
  output logic [DATA_W-1:0] o_rd_data [N]
);

  logic [DATA_W-1:0] r_mem [N][N];

  // Row write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < N; k++) begin
        r_mem[i_wr_row][k] <= i_wr_data[k];
      end
    end
  end

  // Column read port
  always_comb begin
    for (int k = 0; k < N; k++) begin
      o_rd_data[k] = r_mem[k][i_rd_col];
    end
  end

endmodule

// File: rtl/dct2d_pass_sched.sv
// Schedules the row pass and column pass of an 8x8 2-D DCT through one shared,
// in-order 1-D core; ordering is tracked purely by issue/return counters.
module dct2d_pass_sched
  import dct_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = DCT_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data [N],
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_in [N],
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [DATA_W-1:0] core_out [N],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data [N],
  output logic [2:0]        out_col,
  output logic              done,
  output logic              busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_row_iss;
  logic [CNT_W-1:0] r_row_ret;
  logic [CNT_W-1:0] r_col_iss;
  logic [CNT_W-1:0] r_col_ret;
  logic             r_done;

  logic             w_row_phase;
  logic             w_col_phase;
  logic             w_iss_row;
  logic             w_ret_row;
  logic             w_iss_col;
  logic             w_ret_col;
  logic [CNT_W-1:0] w_row_iss_nxt;
  logic [CNT_W-1:0] w_row_ret_nxt;
  logic [CNT_W-1:0] w_col_iss_nxt;
  logic [CNT_W-1:0] w_col_ret_nxt;
  logic [DATA_W-1:0] w_col_data [N];

  assign w_row_phase = (r_state == S_ROW) || (r_state == S_ROW_WAIT);
  assign w_col_phase = (r_state == S_COL) || (r_state == S_COL_WAIT);

  assign w_iss_row = (r_state == S_ROW) && in_valid && core_in_ready;
  assign w_ret_row = w_row_phase && core_out_valid;
  assign w_iss_col = (r_state == S_COL) && core_in_ready;
  assign w_ret_col = w_col_phase && core_out_valid && out_ready;

  assign w_row_iss_nxt = cnt_step(r_row_iss, w_iss_row);
  assign w_row_ret_nxt = cnt_step(r_row_ret, w_ret_row);
  assign w_col_iss_nxt = cnt_step(r_col_iss, w_iss_col);
  assign w_col_ret_nxt = cnt_step(r_col_ret, w_ret_col);

  dct_tpose_buf #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_ret_row),
    .i_wr_row  (r_row_ret[IDX_W-1:0]),
    .i_wr_data (core_out),
    .i_rd_col  (r_col_iss[IDX_W-1:0]),
    .o_rd_data (w_col_data)
  );

  // Handshake steering per phase; reset masks the row-phase issue path
  always_comb begin
    in_ready       = 1'b0;
    core_in_valid  = 1'b0;
    core_out_ready = 1'b0;
    out_valid      = 1'b0;
    case (r_state)
      S_ROW: begin
        in_ready       = core_in_ready;
        core_in_valid  = in_valid && !rst;
        core_out_ready = 1'b1;
      end
      S_ROW_WAIT: begin
        core_out_ready = 1'b1;
      end
      S_COL: begin
        core_in_valid  = 1'b1;
        core_out_ready = out_ready;
        out_valid      = core_out_valid;
      end
      S_COL_WAIT: begin
        core_out_ready = out_ready;
        out_valid      = core_out_valid;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Data path: pure muxing, no registers
  always_comb begin
    for (int k = 0; k < N; k++) begin
      core_in[k]  = (r_state == S_COL) ? w_col_data[k] : in_data[k];
      out_data[k] = core_out[k];
    end
  end

  // Scheduler FSM and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_ROW;
      r_row_iss <= 4'd0;
      r_row_ret <= 4'd0;
      r_col_iss <= 4'd0;
      r_col_ret <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_ROW, S_ROW_WAIT: begin
          r_row_iss <= w_row_iss_nxt;
          r_row_ret <= w_row_ret_nxt;
          // Last return can only close the row pass once all 8 rows are out
          if (w_ret_row && (w_row_ret_nxt == CNT_FULL) && (w_row_iss_nxt == CNT_FULL)) begin
            r_state <= S_COL;
          end else if (w_iss_row && (w_row_iss_nxt == CNT_FULL)) begin
            r_state <= S_ROW_WAIT;
          end else begin
            r_state <= r_state;
          end
        end
        S_COL, S_COL_WAIT: begin
          if (w_ret_col && (w_col_ret_nxt == CNT_FULL)) begin
            r_state   <= S_ROW;
            r_row_iss <= 4'd0;
            r_row_ret <= 4'd0;
            r_col_iss <= 4'd0;
            r_col_ret <= 4'd0;
            r_done    <= 1'b1;
          end else begin
            r_col_iss <= w_col_iss_nxt;
            r_col_ret <= w_col_ret_nxt;
            if (w_iss_col && (w_col_iss_nxt == CNT_FULL)) begin
              r_state <= S_COL_WAIT;
            end else begin
              r_state <= r_state;
            end
          end
        end
        default: begin
          r_state <= S_ROW;
        end
      endcase
    end
  end

  assign out_col = r_col_ret[2:0];
  assign done    = r_done;
  assign busy    = (r_state != S_ROW) || (r_row_iss != 4'd0);

endmodule

// File: tb/tb_dct2d_pass_sched.sv
// Directed bench for dct2d_pass_sched with an in-order model core and a
// golden 2-D reference built from the same 1-D core function.
module tb_dct2d_pass_sched;

  localparam int W = 32;
  typedef logic [7:0][W-1:0] pvec_t;

  typedef struct {
    logic rst, iv, cir, cov;
    logic [4:0] exp;
  } vec_t;
  typedef struct { pvec_t data; int due; } ent_t;
  typedef struct { logic [2:0] col; pvec_t data; } cap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data [8];
  logic         core_in_valid, core_in_ready;
  logic [W-1:0] core_in [8];
  logic         core_out_valid, core_out_ready;
  logic [W-1:0] mdl_out [8];
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] out_data [8];
  logic [2:0]   out_col;
  logic         done, busy;

  logic mdl_ov = 1'b0, mdl_cir = 1'b1;
  logic force_mode = 1'b1, t_cov = 1'b0, t_cir = 1'b1;
  int   lat_mode = 0, cir_mode = 0;

  assign core_in_ready  = force_mode ? t_cir : mdl_cir;
  assign core_out_valid = force_mode ? t_cov : mdl_ov;

  int checks = 0, failures = 0;
  int cyc = 0, last_due = 0;
  ent_t q[$];
  cap_t cap[$];
  int   done_q[$];
  int   acc_q[$];

  pvec_t rows_a[8], rows_b[8], rows_c[8];

  dct2d_pass_sched #(.DATA_W(W), .N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in(core_in),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out(mdl_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .done(done), .busy(busy)
  );

  function automatic pvec_t core_f(input pvec_t v);
    pvec_t r;
    for (int k = 0; k < 8; k++) r[k] = v[k] * 32'(k + 1) + v[7-k];
    return r;
  endfunction

  function automatic pvec_t pack(input logic [W-1:0] a [8]);
    pvec_t p;
    for (int k = 0; k < 8; k++) p[k] = a[k];
    return p;
  endfunction

  function automatic void golden(input pvec_t rows [8], output pvec_t cols [8]);
    pvec_t rr [8];
    pvec_t cv;
    for (int r = 0; r < 8; r++) rr[r] = core_f(rows[r]);
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) cv[r] = rr[r][c];
      cols[c] = core_f(cv);
    end
  endfunction

  // In-order model core plus capture of output/done/accept events
  always @(posedge clk) begin
    int lat, due;
    cyc = cyc + 1;
    mdl_cir <= (cir_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (rst) begin
      q.delete();
      last_due = 0;
      mdl_ov <= 1'b0;
    end else begin
      if (out_valid && out_ready) cap.push_back('{out_col, pack(out_data)});
      if (done) done_q.push_back(cyc);
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (core_out_valid && core_out_ready && q.size() > 0) q.delete(0);
      if (core_in_valid && core_in_ready) begin
        lat = (lat_mode == 0) ? 3 : int'($urandom_range(1, 10));
        due = cyc + lat - 1;
        if (due < last_due) due = last_due;
        last_due = due;
        q.push_back('{core_f(pack(core_in)), due});
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        mdl_ov <= 1'b1;
        for (int k = 0; k < 8; k++) mdl_out[k] <= q[0].data[k];
      end else begin
        mdl_ov <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_row(input pvec_t r);
    int t = 0;
    logic hs = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) in_data[k] = r[k];
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!hs) chk("row_accept_timeout", 256'(hs), 256'(1));
  endtask

  task automatic wait_done_neg();
    int t = 0;
    logic prev_busy = 1'b0;
    logic seen = 1'b0;
    while (!seen && t < 500) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else prev_busy = busy;
      t++;
    end
    chk("done_seen", 256'(seen), 256'(1));
    chk("busy_before_done", 256'(prev_busy), 256'(1));
    chk("busy_at_done", 256'(busy), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_done_count(input int target);
    int t = 0;
    while (done_q.size() < target && t < 800) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_count_wait", 256'(done_q.size() >= target), 256'(1));
  endtask

  task automatic check_block(input string nm, input pvec_t rows [8], input int base);
    pvec_t exp [8];
    golden(rows, exp);
    for (int c = 0; c < 8; c++) begin
      if (cap.size() > base + c) begin
        chk({nm, "_col_idx"}, 256'(cap[base+c].col), 256'(c));
        chk({nm, "_col_data"}, cap[base+c].data, exp[c]);
      end else begin
        chk({nm, "_col_missing"}, 256'(cap.size()), 256'(base + c + 1));
      end
    end
  endtask

  initial begin
    vec_t tbl [9];
    int base, d0, a0;

    // {rst, in_valid, core_in_ready, core_out_valid} -> {in_ready, core_in_valid, core_out_ready, out_valid, busy}
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b10100};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b10100};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01100};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11100};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00101};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b10101};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11101};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10100};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        rows_a[r][k] = 32'(8 * r + k);
        rows_b[r][k] = $urandom;
        rows_c[r][k] = $urandom;
      end
    end
    for (int k = 0; k < 8; k++) in_data[k] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_core_in_valid", 256'(core_in_valid), 256'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; t_cir = tbl[i].cir; t_cov = tbl[i].cov;
      @(negedge clk);
      chk($sformatf("tbl%0d", i), 256'({in_ready, core_in_valid, core_out_ready, out_valid, busy}),
          256'(tbl[i].exp));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    force_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ramp block, fixed 3-cycle core
    base = cap.size(); d0 = done_q.size();
    for (int r = 0; r < 8; r++) send_row(rows_a[r]);
    in_valid = 1'b0;
    wait_done_neg();
    repeat (5) @(posedge clk);
    #1;
    chk("ramp_done_once", 256'(done_q.size() - d0), 256'(1));
    chk("ramp_ncols", 256'(cap.size() - base), 256'(8));
    chk("ramp_busy_after", 256'(busy), 256'(0));
    check_block("ramp", rows_a, base);

    // Random latency, toggling core_in_ready
    lat_mode = 1; cir_mode = 1;
    base = cap.size();
    for (int r = 0; r < 8; r++) send_row(rows_b[r]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_8th", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    wait_done_neg();
    check_block("rand", rows_b, base);

    // Output backpressure during the column pass
    lat_mode = 0; cir_mode = 0;
    base = cap.size();
    for (int r = 0; r < 8; r++) send_row(rows_c[r]);
    in_valid = 1'b0;
    begin
      int t = 0;
      logic seen = 1'b0;
      while (!seen && t < 200) begin
        @(negedge clk);
        seen = core_in_valid;
        t++;
      end
      chk("col_phase_seen", 256'(seen), 256'(1));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("stall_core_out_ready", 256'(core_out_ready), 256'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done_neg();
    repeat (3) @(posedge clk);
    #1;
    chk("stall_ncols", 256'(cap.size() - base), 256'(8));
    check_block("stall", rows_c, base);

    // Reset after 5 rows, then a full block
    lat_mode = 1; cir_mode = 1;
    for (int r = 0; r < 5; r++) send_row(rows_b[r]);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_q.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("in_ready_follows", 256'(in_ready), 256'(core_in_ready));
    end
    @(posedge clk); #1;
    base = cap.size();
    for (int r = 0; r < 8; r++) send_row(rows_a[r]);
    in_valid = 1'b0;
    wait_done_neg();
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_done_once", 256'(done_q.size() - d0), 256'(1));
    check_block("postrst", rows_a, base);

    // Back-to-back blocks with in_valid held high
    lat_mode = 0; cir_mode = 0;
    base = cap.size(); d0 = done_q.size(); a0 = acc_q.size();
    for (int r = 0; r < 8; r++) send_row(rows_b[r]);
    for (int r = 0; r < 8; r++) send_row(rows_c[r]);
    in_valid = 1'b0;
    wait_done_count(d0 + 2);
    chk("b2b_accepts", 256'(acc_q.size() - a0), 256'(16));
    if (acc_q.size() > a0 + 8 && done_q.size() > d0)
      chk("b2b_refused_until_done", 256'(acc_q[a0+8] >= done_q[d0]), 256'(1));
    else
      chk("b2b_events_missing", 256'(0), 256'(1));
    chk("b2b_ncols", 256'(cap.size() - base), 256'(16));
    check_block("b2b_first", rows_b, base);
    check_block("b2b_second", rows_c, base + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
